player_missile_ctrl: RTL and testbench

//  Player shot controller, downstream of the player movement block. Consumes the

---
 rtl/player_missile_ctrl.sv | 113 +++++++++++
 tb/tb_player_missile_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_missile_ctrl.sv
// Player shot controller: launches one missile from the player's cannon, moves it
// up once per frame in 1/64-pixel fixed point, and retires it on hit or at the top.
module player_missile_ctrl #(
    parameter int X_OFFSET        = 30,
    parameter int MISSILE_HEIGHT  = 16,
    parameter int MISSILE_SPEED   = 256,
    parameter int TOP_LIMIT       = 8,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               playGame,
    input  logic               enter,
    input  logic signed [10:0] playerTopLeftX,
    input  logic signed [10:0] playerTopLeftY,
    input  logic               missileHit,
    output logic signed [10:0] missileTopLeftX,
    output logic signed [10:0] missileTopLeftY,
    output logic               missileActive,
    output logic               shotFired
);

    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

    localparam logic signed [10:0] TOP_PX = 11'(TOP_LIMIT);
    localparam logic [15:0]        COOL_LOAD = 16'(COOLDOWN_FRAMES);

    state_t             state, next_state;
    logic               enter_d;
    logic               fire;
    logic signed [17:0] x_fp, y_fp;
    logic signed [17:0] y_next, launch_x, launch_y;
    logic signed [10:0] y_next_px;
    logic               top_reached;
    logic [15:0]        cool_cnt;
    logic               unused_bits;

    assign fire        = enter & ~enter_d;
    assign launch_x    = (18'(playerTopLeftX) + 18'(X_OFFSET)) <<< 6;
    assign launch_y    = (18'(playerTopLeftY) - 18'(MISSILE_HEIGHT)) <<< 6;
    assign y_next      = y_fp - 18'(MISSILE_SPEED);
    assign y_next_px   = y_next[16:6];
    assign top_reached = (y_next_px <= TOP_PX);
    assign unused_bits = ^{x_fp[17], x_fp[5:0]};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else if (!playGame)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Hit outranks movement; a cooldown reaching zero on a frame leaves in that same update.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (fire) next_state = FLYING;
            FLYING: begin
                if (missileHit)
                    next_state = COOLDOWN;
                else if (startOfFrame && top_reached)
                    next_state = COOLDOWN;
            end
            COOLDOWN: begin
                if (cool_cnt == '0)
                    next_state = IDLE;
                else if (startOfFrame && cool_cnt == 16'd1)
                    next_state = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        missileActive   = (state == FLYING);
        missileTopLeftX = missileActive ? x_fp[16:6] : '0;
        missileTopLeftY = missileActive ? y_fp[16:6] : '0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            enter_d   <= 1'b0;
            shotFired <= 1'b0;
            x_fp      <= '0;
            y_fp      <= '0;
            cool_cnt  <= '0;
        end else if (!playGame) begin
            enter_d   <= 1'b0;
            shotFired <= 1'b0;
            x_fp      <= '0;
            y_fp      <= '0;
            cool_cnt  <= '0;
        end else begin
            enter_d   <= enter;
            shotFired <= 1'b0;
            if (state == IDLE && fire) begin
                x_fp      <= launch_x;
                y_fp      <= launch_y;
                shotFired <= 1'b1;
            end else if (state == FLYING && !missileHit && startOfFrame) begin
                y_fp <= y_next;
            end
            if (state == FLYING && next_state == COOLDOWN)
                cool_cnt <= COOL_LOAD;
            else if (state == COOLDOWN && startOfFrame && cool_cnt != '0)
                cool_cnt <= cool_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Scenario bench for player_missile_ctrl: expected outputs are queued when stimulus
// is driven and popped for comparison one clock later.
module tb_player_missile_ctrl;

    typedef struct packed {
        logic        act;
        logic        shot;
        logic [10:0] x;
        logic [10:0] y;
    } out_t;

    logic               clk = 1'b0;
    logic               resetN, startOfFrame, playGame, enter, missileHit;
    logic signed [10:0] playerTopLeftX, playerTopLeftY;
    logic signed [10:0] missileTopLeftX, missileTopLeftY;
    logic               missileActive, shotFired;

    out_t sb[$];
    int   checks = 0;
    int   errors = 0;

    player_missile_ctrl #(
        .X_OFFSET(30), .MISSILE_HEIGHT(16), .MISSILE_SPEED(256),
        .TOP_LIMIT(8), .COOLDOWN_FRAMES(10)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
        .enter(enter), .playerTopLeftX(playerTopLeftX), .playerTopLeftY(playerTopLeftY),
        .missileHit(missileHit), .missileTopLeftX(missileTopLeftX),
        .missileTopLeftY(missileTopLeftY), .missileActive(missileActive), .shotFired(shotFired)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic a, input logic s, input int x, input int y);
        out_t r;
        r.act  = a;
        r.shot = s;
        r.x    = 11'(x);
        r.y    = 11'(y);
        return r;
    endfunction

    function automatic out_t obs();
        out_t r;
        r.act  = missileActive;
        r.shot = shotFired;
        r.x    = missileTopLeftX;
        r.y    = missileTopLeftY;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic clear_game();
        enter = 1'b0; missileHit = 1'b0; startOfFrame = 1'b0;
        playGame = 1'b0;
        tick();
        playGame = 1'b1;
        playerTopLeftX = 11'sd240;
        playerTopLeftY = 11'sd420;
        tick();
    endtask

    task automatic test_reset();
        out_t e, o;
        resetN = 1'b0; playGame = 1'b1; enter = 1'b0; missileHit = 1'b0; startOfFrame = 1'b0;
        playerTopLeftX = 11'sd240; playerTopLeftY = 11'sd420;
        sb.push_back(mk(0, 0, 0, 0));
        tick(); tick();
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                     o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
        end
        @(negedge clk);
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_launch_flight();
        out_t e, o;
        int   y;
        for (int step = 0; step < 99 + 2; step++) begin
            if (step == 0) begin
                enter = 1'b1;
                sb.push_back(mk(1, 1, 270, 404));
                tick();
            end else if (step == 1) begin
                enter = 1'b0;
                sb.push_back(mk(1, 0, 270, 404));
                tick();
            end else begin
                if (step == 11) playerTopLeftX = 11'sd400;
                y = 404 - 4 * (step - 1);
                sb.push_back(y > 8 ? mk(1, 0, 270, y) : mk(0, 0, 0, 0));
                frame();
            end
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flight step %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                         step, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
            end
        end
        // cooldown presses after frames 1..9 are ignored, after frame 10 it launches
        for (int f = 1; f <= 10; f++) begin
            frame();
            enter = 1'b1;
            sb.push_back(f < 10 ? mk(0, 0, 0, 0) : mk(1, 1, 430, 404));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cooldown press %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                         f, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
            end
            enter = 1'b0;
            tick();
        end
        // playGame low mid-flight clears on the next clock; next press launches again
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                playGame = 1'b0;
                sb.push_back(mk(0, 0, 0, 0));
            end else begin
                playGame = 1'b1;
                enter = 1'b1;
                sb.push_back(mk(1, 1, 430, 404));
            end
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL playgame %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                         k, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
            end
        end
        clear_game();
    endtask

    task automatic test_hold();
        out_t e, o;
        int   y;
        enter = 1'b1;
        for (int step = 0; step < 1 + 99 + 10 + 3; step++) begin
            if (step == 0) begin
                sb.push_back(mk(1, 1, 270, 404));
                tick();
            end else if (step <= 99) begin
                y = 404 - 4 * step;
                sb.push_back(y > 8 ? mk(1, 0, 270, y) : mk(0, 0, 0, 0));
                frame();
            end else if (step <= 109) begin
                sb.push_back(mk(0, 0, 0, 0));
                frame();
            end else begin
                sb.push_back(mk(0, 0, 0, 0));
                tick();
            end
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hold step %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                         step, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
            end
        end
        enter = 1'b0;
        tick();
        enter = 1'b1;
        sb.push_back(mk(1, 1, 270, 404));
        tick();
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL hold repress: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                     o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
        end
        clear_game();
    endtask

    task automatic test_hit();
        out_t e, o;
        for (int step = 0; step < 9; step++) begin
            case (step)
                0: begin  // hit in IDLE ignored, launch proceeds
                    missileHit = 1'b1; enter = 1'b1;
                    sb.push_back(mk(1, 1, 270, 404));
                    tick();
                    missileHit = 1'b0; enter = 1'b0;
                end
                1, 2, 3, 4, 5: begin
                    sb.push_back(mk(1, 0, 270, 404 - 4 * step));
                    frame();
                end
                6: begin  // hit coincident with frame: retire
                    missileHit = 1'b1; startOfFrame = 1'b1;
                    sb.push_back(mk(0, 0, 0, 0));
                    tick();
                    missileHit = 1'b0; startOfFrame = 1'b0;
                end
                7: begin  // relaunch after 10 cooldown frames, then hit without a frame
                    for (int f = 0; f < 10; f++) frame();
                    enter = 1'b1;
                    sb.push_back(mk(1, 1, 270, 404));
                    tick();
                    enter = 1'b0;
                end
                default: begin
                    missileHit = 1'b1;
                    sb.push_back(mk(0, 0, 0, 0));
                    tick();
                    missileHit = 1'b0;
                end
            endcase
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hit step %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                         step, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
            end
        end
        clear_game();
    endtask

    task automatic test_sof_fire();
        out_t e, o;
        for (int step = 0; step < 3; step++) begin
            if (step == 0) begin
                enter = 1'b1; startOfFrame = 1'b1;
                sb.push_back(mk(1, 1, 270, 404));
                tick();
                enter = 1'b0; startOfFrame = 1'b0;
            end else if (step == 1) begin
                sb.push_back(mk(1, 0, 270, 404));
                tick();
            end else begin
                sb.push_back(mk(1, 0, 270, 400));
                frame();
            end
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sof_fire step %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                         step, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
            end
        end
        clear_game();
    endtask

    task automatic test_async_reset();
        out_t e, o;
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: begin
                    enter = 1'b1;
                    sb.push_back(mk(1, 1, 270, 404));
                    tick();
                    enter = 1'b0;
                end
                1: begin  // reset between edges mid-flight clears outputs at once
                    frame();
                    #2 resetN = 1'b0;
                    sb.push_back(mk(0, 0, 0, 0));
                    #1;
                end
                2: begin  // reset mid-cooldown, then a press launches without waiting
                    @(negedge clk); resetN = 1'b1; tick();
                    enter = 1'b1; tick(); enter = 1'b0;
                    missileHit = 1'b1; tick(); missileHit = 1'b0;
                    frame(); frame();
                    #2 resetN = 1'b0;
                    #1;
                    @(negedge clk); resetN = 1'b1;
                    tick();
                    enter = 1'b1;
                    sb.push_back(mk(1, 1, 270, 404));
                    tick();
                    enter = 1'b0;
                end
                default: begin
                    sb.push_back(mk(1, 0, 270, 400));
                    frame();
                end
            endcase
            if (step != 0 || sb.size() != 0) begin
                e = sb.pop_front(); o = obs(); checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL areset step %0d: got act=%0b shot=%0b x=%0d y=%0d want act=%0b shot=%0b x=%0d y=%0d",
                             step, o.act, o.shot, $signed(o.x), $signed(o.y), e.act, e.shot, $signed(e.x), $signed(e.y));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_launch_flight();
        test_hold();
        test_hit();
        test_sof_fire();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
